// File: rtl/spi_fl_read_seq.sv
// Block-read sequencer for spi_master_fl: one 32-bit READ frame per requested word.
// Latency: 2 cycles from request accept to first fl_validflag when the master is idle.
// Backpressure: rd_valid/rd_data hold until rd_ready; the next frame is not issued until the word is taken.
module spi_fl_read_seq #(
  parameter logic [7:0] CMD_READ    = 8'h03,
  parameter logic [7:0] CMD_FREAD   = 8'h0B,
  parameter logic [2:0] COMMTYPE_RD = 3'b001,
  parameter logic [9:0] FRAME_RD    = 10'h000,
  parameter logic [3:0] FREAD_DUMMY = 4'd8,
  parameter int         TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_nwords,
  input  logic        req_fast,
  input  logic        abort,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] fl_data_in,
  output logic [23:0] fl_address,
  output logic [7:0]  fl_command,
  output logic [2:0]  fl_commtype,
  output logic [6:0]  fl_ndata_bits,
  output logic [9:0]  fl_frame_struct,
  output logic [3:0]  fl_dummy_cycles,
  output logic        fl_validflag,
  input  logic        fl_tready,
  input  logic        fl_validflag_out,
  input  logic [31:0] fl_data_out
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DATA, S_PUSH, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   addr_q, addr_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [3:0]    dummy_q, dummy_d;
  logic [7:0]    count_q, count_d;
  logic          abort_q, abort_d;
  logic          error_q, error_d;
  logic          vflag_q, vflag_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [TW-1:0] timer_q, timer_d;

  logic timer_expired;
  assign timer_expired = (timer_q == TW'(TIMEOUT - 1));

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cmd_q     <= CMD_READ;
      dummy_q   <= '0;
      count_q   <= '0;
      abort_q   <= 1'b0;
      error_q   <= 1'b0;
      vflag_q   <= 1'b0;
      rd_data_q <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      dummy_q   <= dummy_d;
      count_q   <= count_d;
      abort_q   <= abort_d;
      error_q   <= error_d;
      vflag_q   <= vflag_d;
      rd_data_q <= rd_data_d;
      timer_q   <= timer_d;
    end
  end

  // Next-state logic: frame sequencing, abort latching at frame boundaries, per-frame timeout.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    dummy_d   = dummy_q;
    count_d   = count_q;
    abort_d   = abort_q;
    error_d   = error_q;
    vflag_d   = 1'b0;
    rd_data_d = rd_data_q;
    timer_d   = timer_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          cmd_d   = req_fast ? CMD_FREAD : CMD_READ;
          dummy_d = req_fast ? FREAD_DUMMY : 4'd0;
          count_d = req_nwords;
          error_d = 1'b0;
          abort_d = 1'b0;
          state_d = (req_nwords == 8'd0) ? S_DONE : S_ISSUE;
        end
      end

      S_ISSUE: begin
        abort_d = abort_q | abort;
        // No frame is in flight here, so an abort ends the block right away.
        if (abort_q || abort) begin
          state_d = S_DONE;
        end else if (fl_tready) begin
          vflag_d = 1'b1;
          timer_d = '0;
          state_d = S_WAIT_ACK;
        end
      end

      S_WAIT_ACK: begin
        abort_d = abort_q | abort;
        timer_d = timer_q + TW'(1);
        if (timer_expired) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else if (!fl_tready) begin
          state_d = S_WAIT_DATA;
        end
      end

      S_WAIT_DATA: begin
        abort_d = abort_q | abort;
        timer_d = timer_q + TW'(1);
        // A data strobe on the last allowed cycle still wins over the timeout.
        if (fl_validflag_out) begin
          rd_data_d = fl_data_out;
          state_d   = S_PUSH;
        end else if (timer_expired) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
      end

      S_PUSH: begin
        abort_d = abort_q | abort;
        if (rd_ready) begin
          addr_d  = addr_q + 24'd4;
          count_d = count_q - 8'd1;
          state_d = (count_q == 8'd1 || abort_q || abort) ? S_DONE : S_ISSUE;
        end
      end

      S_DONE: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready       = (state_q == S_IDLE);
  assign rd_valid        = (state_q == S_PUSH);
  assign rd_data         = rd_data_q;
  assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done            = (state_q == S_DONE);
  assign error           = error_q;
  assign fl_data_in      = 32'd0;
  assign fl_address      = addr_q;
  assign fl_command      = cmd_q;
  assign fl_commtype     = COMMTYPE_RD;
  assign fl_ndata_bits   = 7'd32;
  assign fl_frame_struct = FRAME_RD;
  assign fl_dummy_cycles = dummy_q;
  assign fl_validflag    = vflag_q;

endmodule

// File: tb/tb_spi_fl_read_seq.sv
// Bench for spi_fl_read_seq: behavioural flash-master model, randomized consumer and block requests.
// Expected frames are derived from each request (addr + 4*i mod 2^24, command/dummy from the fast flag).
// Returned words are compared against what the master model supplied, in order.
module tb_spi_fl_read_seq;
  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_fast, abort;
  logic [23:0] req_addr;
  logic [7:0]  req_nwords;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready, busy, done, error;
  logic [31:0] fl_data_in;
  logic [23:0] fl_address;
  logic [7:0]  fl_command;
  logic [2:0]  fl_commtype;
  logic [6:0]  fl_ndata_bits;
  logic [9:0]  fl_frame_struct;
  logic [3:0]  fl_dummy_cycles;
  logic        fl_validflag, fl_tready, fl_validflag_out;
  logic [31:0] fl_data_out;

  always #5 clk = ~clk;

  spi_fl_read_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_nwords(req_nwords), .req_fast(req_fast), .abort(abort),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .error(error),
    .fl_data_in(fl_data_in), .fl_address(fl_address), .fl_command(fl_command),
    .fl_commtype(fl_commtype), .fl_ndata_bits(fl_ndata_bits),
    .fl_frame_struct(fl_frame_struct), .fl_dummy_cycles(fl_dummy_cycles),
    .fl_validflag(fl_validflag), .fl_tready(fl_tready),
    .fl_validflag_out(fl_validflag_out), .fl_data_out(fl_data_out)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  cmd;
    logic [3:0]  dummy;
    logic [31:0] data;
  } frame_t;

  frame_t      frames[$];
  logic [31:0] got[$];
  logic [31:0] fixed_data[$];
  int          m_st = 0;
  int          m_dly = 0;
  bit          hang = 0;
  int          hold_cycles = 0;

  // Flash master model: takes a frame when idle, answers after a random delay (or never, when hung).
  initial begin
    frame_t f;
    logic   prev_vf;
    prev_vf = 1'b0;
    fl_tready = 1'b1; fl_validflag_out = 1'b0; fl_data_out = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_st = 0; fl_tready = 1'b1; fl_validflag_out = 1'b0; prev_vf = 1'b0;
      end else begin
        if (fl_validflag) begin
          chk("vf_one_cycle", 32'(prev_vf), 0);
          chk("vf_master_ready", 32'(m_st == 0), 1);
        end
        prev_vf = fl_validflag;
        case (m_st)
          0: begin
            fl_validflag_out = 1'b0;
            if (fl_validflag) begin
              f.addr = fl_address; f.cmd = fl_command; f.dummy = fl_dummy_cycles;
              f.data = (fixed_data.size() > 0) ? fixed_data.pop_front() : $urandom;
              frames.push_back(f);
              chk("fl_data_in", fl_data_in, 0);
              chk("fl_commtype", 32'(fl_commtype), 32'h1);
              chk("fl_ndata_bits", 32'(fl_ndata_bits), 32);
              chk("fl_frame_struct", 32'(fl_frame_struct), 0);
              fl_tready = 1'b0;
              m_dly = $urandom_range(0, 3);
              m_st = 1;
            end
          end
          1: begin
            if (hang) begin
              if (!busy) begin fl_tready = 1'b1; m_st = 0; end
            end else if (m_dly == 0) begin
              fl_validflag_out = 1'b1;
              fl_data_out = frames[frames.size()-1].data;
              m_st = 2;
            end else begin
              m_dly--;
            end
          end
          default: begin
            fl_validflag_out = 1'b0; fl_tready = 1'b1; m_st = 0;
          end
        endcase
      end
    end
  end

  // Consumer: random rd_ready, optional initial stall; checks rd_valid/rd_data hold while stalled.
  initial begin
    bit          prev_wait;
    logic [31:0] held;
    prev_wait = 0; held = '0;
    rd_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rd_ready = 1'b0; prev_wait = 0;
      end else begin
        if (prev_wait) begin
          chk("rd_valid_hold", 32'(rd_valid), 1);
          chk("rd_data_hold", rd_data, held);
        end
        if (rd_valid && hold_cycles > 0) begin
          hold_cycles--;
          rd_ready = 1'b0;
          chk("no_vf_in_stall", 32'(fl_validflag), 0);
        end else begin
          rd_ready = ($urandom_range(0, 3) != 0);
        end
        if (rd_valid && rd_ready) got.push_back(rd_data);
        prev_wait = rd_valid && !rd_ready;
        held = rd_data;
      end
    end
  end

  task automatic run_block(input logic [23:0] addr, input int n, input bit fast,
                           input int abort_frame, input bit do_hang);
    int          cyc, nexp, nw;
    bit          ab_sent;
    logic [23:0] ea;
    frames.delete(); got.delete();
    hang = do_hang;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1; req_addr = addr; req_nwords = 8'(n); req_fast = fast;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 24'($urandom); req_nwords = 8'($urandom); req_fast = 1'($urandom);
    chk("error_clr_on_accept", 32'(error), 0);
    chk("req_ready_low", 32'(req_ready), 0);
    chk("done_after_accept", 32'(done), 32'(n == 0));
    chk("busy_after_accept", 32'(busy), 32'(n != 0));
    if (n != 0) begin
      @(negedge clk);
      chk("first_vf_latency", 32'(fl_validflag), 1);
    end
    cyc = 0; ab_sent = 0;
    while (!done && cyc < 20000) begin
      if (abort_frame >= 0 && !ab_sent && frames.size() > abort_frame) begin
        abort = 1'b1; ab_sent = 1;
      end else begin
        abort = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0;
    chk("done_seen", 32'(done), 1);
    if (do_hang) chk("timeout_cycles", 32'(cyc >= TIMEOUT && cyc <= TIMEOUT + 2), 1);
    chk("busy_at_done", 32'(busy), 0);
    chk("error_at_done", 32'(error), 32'(do_hang));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("req_ready_after", 32'(req_ready), 1);
    chk("error_sticky", 32'(error), 32'(do_hang));
    hang = 0;
    if (do_hang) nexp = 1;
    else if (abort_frame >= 0 && abort_frame < n) nexp = abort_frame + 1;
    else nexp = n;
    nw = do_hang ? 0 : nexp;
    chk("n_frames", 32'(frames.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < frames.size(); i++) begin
      ea = addr + 24'(4 * i);
      chk("frame_addr", 32'(frames[i].addr), 32'(ea));
      chk("frame_cmd", 32'(frames[i].cmd), fast ? 32'h0B : 32'h03);
      chk("frame_dummy", 32'(frames[i].dummy), fast ? 32'd8 : 32'd0);
    end
    chk("n_words", 32'(got.size()), 32'(nw));
    for (int i = 0; i < nw && i < got.size() && i < frames.size(); i++)
      chk("word", got[i], frames[i].data);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cyc, n, ab;
    logic [23:0] a;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_nwords = '0; req_fast = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_fl_command", 32'(fl_command), 32'h03);
    rst = 1'b1;
    @(negedge clk);

    fixed_data.push_back(32'hA0A0A0A3);
    fixed_data.push_back(32'h5A5A5A5A);
    run_block(24'h555555, 2, 1'b0, -1, 1'b0);
    chk("fixed_word0", (got.size() > 0) ? got[0] : 32'hx, 32'hA0A0A0A3);
    chk("fixed_word1", (got.size() > 1) ? got[1] : 32'hx, 32'h5A5A5A5A);

    run_block(24'hFFFFFC, 2, 1'b1, -1, 1'b0);

    hold_cycles = 50;
    run_block(24'($urandom), 3, 1'b0, -1, 1'b0);
    hold_cycles = 0;

    run_block(24'($urandom), 4, 1'b0, 0, 1'b0);
    run_block(24'($urandom), 3, 1'b1, -1, 1'b1);
    run_block(24'($urandom), 0, 1'b0, -1, 1'b0);

    for (int t = 0; t < 24; t++) begin
      n = $urandom_range(0, 6);
      a = ($urandom_range(0, 1) == 1) ? (24'hFFFFF0 | (24'($urandom_range(0, 3)) << 2))
                                      : 24'($urandom);
      ab = (n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      run_block(a, n, 1'($urandom), ab, 1'b0);
    end

    // Asynchronous reset while a frame is outstanding.
    hang = 1; frames.delete();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 24'h123456; req_nwords = 8'd2; req_fast = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (m_st != 1 && cyc < 100) begin @(negedge clk); cyc++; end
    @(negedge clk); @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_error", 32'(error), 0);
    chk("arst_rd_valid", 32'(rd_valid), 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_vf", 32'(fl_validflag), 0);
    chk("arst_addr", 32'(fl_address), 0);
    chk("arst_cmd", 32'(fl_command), 32'h03);
    chk("arst_dummy", 32'(fl_dummy_cycles), 0);
    hang = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
